// File: rtl/iz_neuron_array.sv
// iz_neuron_array
// Time-multiplexed array of N_NEURON Izhikevich neurons sharing one Euler
// update datapath. One integration step visits every neuron, one per cycle.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   ena               global enable; low freezes the step sequencer
//   step_i            pulse that starts one integration step of all neurons
//   cfg_we/addr/mode/cur  per-neuron mode and input current write port
//   obs_addr          neuron shown on v_o/u_o
//   v_o, u_o          observed v/u, integer part, saturated to 8-bit signed
//   spike_o           per-neuron spike flag from that neuron's last update
//   busy_o            step in progress
//   done_o            one-cycle pulse when a step completes
//
// Optional feature: define IZ_AUTOSTEP_EN to add a free-running 2^PRESC
// cycle step generator ORed with step_i.
//
// FSM states:
//   state  | meaning
//   IDLE   | waiting for a step request
//   RUN    | updating neuron idx, one neuron per cycle
//   DONE   | step finished, done_o pulses

module iz_neuron_array #(
  parameter int N_NEURON = 4,
  parameter int W        = 16,
  parameter int FRAC     = 4,
  parameter int IW       = 5,
  parameter int DT_SHIFT = 1,
  parameter int PRESC    = 10,
  localparam int AW      = $clog2(N_NEURON)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                step_i,
  input  logic                cfg_we,
  input  logic [AW-1:0]       cfg_addr,
  input  logic [2:0]          cfg_mode,
  input  logic [IW-1:0]       cfg_cur,
  input  logic [AW-1:0]       obs_addr,
  output logic [7:0]          v_o,
  output logic [7:0]          u_o,
  output logic [N_NEURON-1:0] spike_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int XW = 2*W + 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [AW-1:0]        LAST  = AW'(N_NEURON - 1);
  localparam logic signed [XW-1:0] K5    = XW'(5);
  localparam logic signed [XW-1:0] K140  = XW'(140) <<< FRAC;
  localparam logic signed [XW-1:0] V_TH  = XW'(30) <<< FRAC;
  localparam logic signed [XW-1:0] S_MAX = XW'((1 << (W-1)) - 1);
  localparam logic signed [XW-1:0] S_MIN = XW'(-(1 << (W-1)));
  localparam logic signed [W-1:0]  O_MAX = W'(127);
  localparam logic signed [W-1:0]  O_MIN = W'(-128);
  localparam logic signed [W-1:0]  V_RST = W'(-65 * (1 << FRAC));
  localparam logic signed [W-1:0]  U_RST = W'(-260);

  function automatic logic signed [W-1:0] sat_w(input logic signed [XW-1:0] x);
    if (x > S_MAX)      sat_w = S_MAX[W-1:0];
    else if (x < S_MIN) sat_w = S_MIN[W-1:0];
    else                sat_w = x[W-1:0];
  endfunction

  function automatic logic [7:0] clamp8(input logic signed [W-1:0] x);
    if (x > O_MAX)      clamp8 = 8'h7F;
    else if (x < O_MIN) clamp8 = 8'h80;
    else                clamp8 = x[7:0];
  endfunction

  logic [1:0]              state;
  logic [AW-1:0]           idx;
  logic signed [W-1:0]     v_mem    [N_NEURON];
  logic signed [W-1:0]     u_mem    [N_NEURON];
  logic [2:0]              mode_mem [N_NEURON];
  logic [IW-1:0]           cur_mem  [N_NEURON];

  logic                    auto_req;
  logic                    step_req;

`ifdef IZ_AUTOSTEP_EN
  logic [PRESC-1:0] presc_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   presc_cnt <= '0;
    else if (ena) presc_cnt <= presc_cnt + PRESC'(1);
  end

  // Request on the cycle the counter is about to wrap.
  assign auto_req = &presc_cnt;
`else
  // No generator: constant-false request (PRESC only matters with the counter).
  assign auto_req = (PRESC < 0);
`endif

  assign step_req = step_i | auto_req;

  // Shared Euler datapath, operating on neuron idx.
  logic [2:0]              a_sh, b_sh;
  logic signed [7:0]       c8, d8;
  logic signed [XW-1:0]    vx, ux, cx, c_x, d_x;
  logic signed [XW-1:0]    sq, t1, dv, vn, du, un, us;
  logic                    spk;
  logic signed [W-1:0]     v_nxt, u_nxt;

  always_comb begin
    a_sh = 3'd6;
    b_sh = 3'd2;
    c8   = -8'sd65;
    d8   = 8'sd8;
    case (mode_mem[idx])
      3'd1:    begin a_sh = 3'd6; b_sh = 3'd2; c8 = -8'sd55; d8 = 8'sd4; end
      3'd2:    begin a_sh = 3'd6; b_sh = 3'd2; c8 = -8'sd50; d8 = 8'sd2; end
      3'd3:    begin a_sh = 3'd3; b_sh = 3'd2; c8 = -8'sd65; d8 = 8'sd2; end
      default: begin a_sh = 3'd6; b_sh = 3'd2; c8 = -8'sd65; d8 = 8'sd8; end
    endcase
    vx  = {{(XW-W){v_mem[idx][W-1]}}, v_mem[idx]};
    ux  = {{(XW-W){u_mem[idx][W-1]}}, u_mem[idx]};
    cx  = {{(XW-IW){1'b0}}, cur_mem[idx]};
    c_x = {{(XW-8){c8[7]}}, c8};
    d_x = {{(XW-8){d8[7]}}, d8};
    sq  = (vx * vx) >>> FRAC;
    t1  = (sq * K5) >>> 7;
    dv  = t1 + K5 * vx + K140 - ux + (cx <<< FRAC);
    vn  = vx + (dv >>> DT_SHIFT);
    du  = ((vx >>> b_sh) - ux) >>> a_sh;
    un  = ux + (du >>> DT_SHIFT);
    us  = un + (d_x <<< FRAC);
    spk = (vn >= V_TH);
    v_nxt = spk ? sat_w(c_x <<< FRAC) : sat_w(vn);
    u_nxt = spk ? sat_w(us)           : sat_w(un);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx   <= '0;
    end else if (ena) begin
      case (state)
        S_IDLE: if (step_req) begin
          state <= S_RUN;
          idx   <= '0;
        end
        S_RUN: begin
          if (idx == LAST) state <= S_DONE;
          else             idx   <= idx + AW'(1);
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_NEURON; k++) begin
        v_mem[k] <= V_RST;
        u_mem[k] <= U_RST;
      end
      spike_o <= '0;
    end else if (ena && state == S_RUN) begin
      v_mem[idx]   <= v_nxt;
      u_mem[idx]   <= u_nxt;
      spike_o[idx] <= spk;
    end
  end

  // Config writes land regardless of FSM state; a neuron being updated this
  // cycle still sees its old mode/current because the datapath reads the regs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_NEURON; k++) begin
        mode_mem[k] <= 3'd0;
        cur_mem[k]  <= '0;
      end
    end else if (cfg_we) begin
      mode_mem[cfg_addr] <= cfg_mode;
      cur_mem[cfg_addr]  <= cfg_cur;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_o <= clamp8(V_RST >>> FRAC);
      u_o <= clamp8(U_RST >>> FRAC);
    end else begin
      v_o <= clamp8(v_mem[obs_addr] >>> FRAC);
      u_o <= clamp8(u_mem[obs_addr] >>> FRAC);
    end
  end

  assign busy_o = (state == S_RUN);
  // A frozen DONE holds its pulse until ena returns.
  assign done_o = (state == S_DONE) && ena;

endmodule

// File: tb/tb_iz_neuron_array.sv
// tb_iz_neuron_array
// Directed bench for iz_neuron_array (N_NEURON = 4, default widths).
// Table vectors cover one step from reset in several mode/current mixes;
// hand-written sequences cover handshake timing, spiking, mode comparison,
// reset mid-step and the ena freeze. A small integer model of the update
// equations tracks every neuron so each observed value can be compared.

module tb_iz_neuron_array;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ena = 1'b1;
  logic         step_i = 1'b0;
  logic         cfg_we = 1'b0;
  logic [1:0]   cfg_addr = 2'd0;
  logic [2:0]   cfg_mode = 3'd0;
  logic [4:0]   cfg_cur = 5'd0;
  logic [1:0]   obs_addr = 2'd0;
  logic [7:0]   v_o, u_o;
  logic [N-1:0] spike_o;
  logic         busy_o, done_o;

  iz_neuron_array #(.N_NEURON(N)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .step_i(step_i),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_mode(cfg_mode), .cfg_cur(cfg_cur),
    .obs_addr(obs_addr), .v_o(v_o), .u_o(u_o), .spike_o(spike_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         mode;
    int         cur;
    logic [7:0] ev;
    logic [7:0] eu;
  } vec_t;

  vec_t tbl [N];

  int     n_total = 0;
  int     n_pass  = 0;
  longint mv [N];
  longint mu [N];
  int     mmode [N];
  int     mcur [N];
  logic   mspk [N];

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual %0d, required %0d", name, act, exp);
  endtask

  function automatic longint sat16(input longint x);
    if (x > 32767)  return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  function automatic longint o8(input longint x);
    longint y;
    y = x >>> 4;
    if (y > 127)  y = 127;
    if (y < -128) y = -128;
    return y & 255;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mv[k] = -1040; mu[k] = -260; mmode[k] = 0; mcur[k] = 0; mspk[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    longint v, u, sq, t1, dv, vn, du, un, a, b, c, d;
    for (int k = 0; k < N; k++) begin
      case (mmode[k])
        1:       begin a = 6; b = 2; c = -55; d = 4; end
        2:       begin a = 6; b = 2; c = -50; d = 2; end
        3:       begin a = 3; b = 2; c = -65; d = 2; end
        default: begin a = 6; b = 2; c = -65; d = 8; end
      endcase
      v  = mv[k];
      u  = mu[k];
      sq = (v * v) >>> 4;
      t1 = (sq * 5) >>> 7;
      dv = t1 + 5 * v + 2240 - u + longint'(mcur[k]) * 16;
      vn = v + (dv >>> 1);
      du = ((v >>> b) - u) >>> a;
      un = u + (du >>> 1);
      if (vn >= 480) begin
        mv[k] = c * 16; mu[k] = sat16(un + d * 16); mspk[k] = 1'b1;
      end else begin
        mv[k] = sat16(vn); mu[k] = sat16(un); mspk[k] = 1'b0;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cyc();
    cyc();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cyc();
  endtask

  task automatic cfg(input int addr, input int mode, input int cur);
    cfg_addr = 2'(addr); cfg_mode = 3'(mode); cfg_cur = 5'(cur); cfg_we = 1'b1;
    cyc();
    cfg_we = 1'b0;
    mmode[addr] = mode;
    mcur[addr]  = cur;
  endtask

  task automatic do_step(output int nbusy);
    int got;
    nbusy = 0; got = 0;
    step_i = 1'b1;
    cyc();
    step_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done_o) begin got = 1; break; end
      if (busy_o) nbusy++;
      cyc();
    end
    check("step_completes", got, 1);
    cyc();
    model_step();
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < N; k++) begin
      obs_addr = 2'(k);
      cyc();
      check($sformatf("%s_v%0d", tag, k), v_o, o8(mv[k]));
      check($sformatf("%s_u%0d", tag, k), u_o, o8(mu[k]));
      check($sformatf("%s_spk%0d", tag, k), spike_o[k], mspk[k]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout, required $finish");
    $fatal(1);
  end

  initial begin
    int nb, got, saw, s_sp, first2, first3;

    tbl[0] = '{mode: 0, cur: 0,  ev: 8'hBD, eu: 8'hEF};
    tbl[1] = '{mode: 1, cur: 10, ev: 8'hC2, eu: 8'hEF};
    tbl[2] = '{mode: 3, cur: 31, ev: 8'hCC, eu: 8'hEF};
    tbl[3] = '{mode: 5, cur: 20, ev: 8'hC7, eu: 8'hEF};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_spike", spike_o, 0);
    check("rst_vo_async", v_o, 8'hBF);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < N; k++) begin
      obs_addr = 2'(k);
      cyc();
      check($sformatf("rst_v%0d", k), v_o, 8'hBF);
      check($sformatf("rst_u%0d", k), u_o, 8'hEF);
    end

    // Handshake: busy t+1..t+4, done at t+5; pulses during RUN and DONE ignored
    step_i = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      cyc();
      if (c == 1 || c == 3 || c == 6) step_i = 1'b0;
      check($sformatf("hs_busy_c%0d", c), busy_o, (c <= 4) ? 1 : 0);
      check($sformatf("hs_done_c%0d", c), done_o, (c == 5) ? 1 : 0);
      if (c == 2 || c == 5) step_i = 1'b1;
    end
    model_step();
    obs_addr = 2'd0;
    cyc();
    check("step1_n0_vo", v_o, 8'hBD);
    check("step1_n0_uo", u_o, 8'hEF);
    check("step1_n0_spk", spike_o[0], 0);
    check_all("step1");

    // Table vectors: one step from reset per mode/current mix
    do_reset();
    for (int i = 0; i < N; i++) cfg(i, tbl[i].mode, tbl[i].cur);
    do_step(nb);
    check("tbl_busy_len", nb, 4);
    for (int i = 0; i < N; i++) begin
      obs_addr = 2'(i);
      cyc();
      check($sformatf("tbl_v%0d", i), v_o, tbl[i].ev);
      check($sformatf("tbl_u%0d", i), u_o, tbl[i].eu);
      check($sformatf("tbl_spk%0d", i), spike_o[i], 0);
    end
    check_all("tbl_model");

    // Neuron 1 driven hard until it spikes
    do_reset();
    cfg(1, 0, 31);
    s_sp = 0;
    for (int s = 1; s <= 20; s++) begin
      do_step(nb);
      check_all($sformatf("drive_s%0d", s));
      if (spike_o[1]) begin s_sp = s; break; end
    end
    check("n1_spike_step", s_sp, 4);
    obs_addr = 2'd1;
    cyc();
    check("n1_spike_vo", v_o, 8'hBF);
    check("n1_spike_uo", u_o, 8'hF7);
    check("others_quiet", spike_o & 4'b1101, 0);

    // Mode 3 vs mode 0, and mode 5 aliasing mode 0
    do_reset();
    cfg(0, 5, 31);
    cfg(2, 3, 31);
    cfg(3, 0, 31);
    first2 = 0; first3 = 0;
    for (int s = 1; s <= 8; s++) begin
      do_step(nb);
      if (spike_o[2] && first2 == 0) first2 = s;
      if (spike_o[3] && first3 == 0) first3 = s;
      check($sformatf("alias_spk_s%0d", s), spike_o[0], spike_o[3]);
      check_all($sformatf("modes_s%0d", s));
    end
    check("mode0_first_spike", first3, 4);
    check("mode3_not_later", (first2 != 0 && first2 <= first3) ? 1 : 0, 1);

    // Reset while updating idx = 2
    do_reset();
    obs_addr = 2'd0;
    step_i = 1'b1;
    cyc();
    step_i = 1'b0;
    cyc();
    cyc();
    check("midrst_pre_busy", busy_o, 1);
    check("midrst_pre_vo", v_o, 8'hBD);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy_o, 0);
    check("midrst_done", done_o, 0);
    check("midrst_vo", v_o, 8'hBF);
    check("midrst_spike", spike_o, 0);
    saw = 0;
    repeat (3) begin cyc(); if (done_o) saw = 1; end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (3) begin cyc(); if (done_o) saw = 1; end
    check("midrst_no_done", saw, 0);
    do_step(nb);
    check("midrst_restep_busy", nb, 4);
    check_all("midrst_restep");

    // ena low: step_i ignored, sequencer and done pulse frozen
    ena = 1'b0;
    step_i = 1'b1;
    cyc();
    step_i = 1'b0;
    cyc();
    check("ena0_no_start", busy_o, 0);
    ena = 1'b1;
    cyc();
    check("ena0_not_latched", busy_o, 0);
    step_i = 1'b1;
    cyc();
    step_i = 1'b0;
    cyc();
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check($sformatf("frz_busy_%0d", i), busy_o, 1);
      check($sformatf("frz_done_%0d", i), done_o, 0);
    end
    ena = 1'b1;
    nb = 0; got = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (done_o) begin got = 1; break; end
      if (busy_o) nb++;
    end
    check("frz_resume_busy", nb, 2);
    check("frz_resume_done", got, 1);
    ena = 1'b0;
    #1;
    check("frz_in_done_low", done_o, 0);
    cyc();
    cyc();
    check("frz_in_done_held", done_o, 0);
    check("frz_in_done_busy", busy_o, 0);
    ena = 1'b1;
    #1;
    check("frz_done_released", done_o, 1);
    cyc();
    check("frz_done_once", done_o, 0);
    model_step();
    check_all("ena");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
